// File: rtl/cfg_pkg.sv
// ---------------------------------------------------------------------------
// cfg_pkg
//   Shared definitions between the control unit and the config memory unit.
//   - CFG_W / KEY_W : config word and system key widths.
//   - ST_*          : state codes the control unit drives on its debug state
//                     output; kept here so both sides decode the same values.
//   - KEY_INIT_DEFAULT : system key value after reset.
// ---------------------------------------------------------------------------
package cfg_pkg;

  localparam int CFG_W = 35;
  localparam int KEY_W = 2;

  // Control unit debug state codes.
  localparam logic [2:0] ST_IDLE    = 3'b001;
  localparam logic [2:0] ST_ACTIVE  = 3'b010;
  localparam logic [2:0] ST_REQUEST = 3'b011;
  localparam logic [2:0] ST_STORE   = 3'b100;
  localparam logic [2:0] ST_TRAP    = 3'b101;
  localparam logic [2:0] ST_OTHERS  = 3'b111;

  localparam logic [KEY_W-1:0] KEY_INIT_DEFAULT = 2'b10;

endpackage

// File: rtl/cfg_mem_array.sv
// ---------------------------------------------------------------------------
// cfg_mem_array
//   DEPTH x DATA_W register file, one synchronous write port and one
//   asynchronous read port. Storage is deliberately not reset.
// Ports
//   clk      in   clock, posedge
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_raddr  in   read address
//   o_rdata  out  mem[i_raddr], combinational
// ---------------------------------------------------------------------------
module cfg_mem_array
  import cfg_pkg::*;
#(
  parameter int DATA_W = CFG_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/config_mem_unit.sv
// ---------------------------------------------------------------------------
// config_mem_unit
//   Captures config words from the control unit into a DEPTH-entry circular
//   buffer and returns them in order on a first-word-fall-through read port.
//   Also sources the system key used by the control unit's password check.
//
// Handshake: a word leaves the buffer in any cycle where rd_valid && rd_ready
//   are both high at the clock edge; rd_data is held stable while rd_valid is
//   high and rd_ready is low. write_en has no ready: a push into a full buffer
//   without a simultaneous pop is dropped and recorded in the sticky overflow.
//
// Ports
//   clk       in   clock, posedge
//   arst_n    in   synchronous active-low reset
//   write_en  in   push request
//   configin  in   config word to push
//   clear     in   synchronous flush of buffer and overflow (key untouched)
//   rd_ready  in   consumer accepts rd_data this cycle
//   rd_valid  out  buffer non-empty
//   rd_data   out  oldest stored word
//   count     out  occupied entries, 0..DEPTH
//   full      out  count == DEPTH
//   overflow  out  sticky dropped-push flag
//   syskey    out  system key
//
// Configuration macro CONFIG_MEM_KEY_ROTATE_EN:
//   defined   -> syskey increments (mod 4) on every accepted push.
//   undefined -> syskey is the constant KEY_INIT.
//
// The occupancy FSM (EMPTY / PARTIAL / FULL) has no separate state register;
// its state is the count output itself.
// ---------------------------------------------------------------------------
module config_mem_unit
  import cfg_pkg::*;
#(
  parameter int               DATA_W   = CFG_W,
  parameter int               DEPTH    = 4,
  parameter logic [KEY_W-1:0] KEY_INIT = KEY_INIT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       write_en,
  input  logic [DATA_W-1:0]          configin,
  input  logic                       clear,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  output logic [KEY_W-1:0]           syskey
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic w_full;
  logic w_rd_valid;
  logic w_pop;
  logic w_push;
  logic w_mem_we;

  // Status comes only from registered count, so write_en never reaches it
  // combinationally.
  assign w_full     = (r_count == DEPTH_C);
  assign w_rd_valid = (r_count != '0);
  assign w_pop      = w_rd_valid && rd_ready;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign w_push     = write_en && (!w_full || w_pop);
  // Reset and clear both suppress the write so no stale push lands in storage.
  assign w_mem_we   = w_push && arst_n && !clear;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer rollover is the wrap.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (write_en && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef CONFIG_MEM_KEY_ROTATE_EN
  logic [KEY_W-1:0] r_syskey;

  // Every stored word forces a new password; dropped pushes do not.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_syskey <= KEY_INIT;
    end else if (!clear && w_push) begin
      r_syskey <= r_syskey + 1'b1;
    end
  end

  assign syskey = r_syskey;
`else
  assign syskey = KEY_INIT;
`endif

  cfg_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (configin),
    .i_raddr (r_rd_ptr),
    .o_rdata (rd_data)
  );

  assign rd_valid = w_rd_valid;
  assign count    = r_count;
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_config_mem_unit.sv
module tb_config_mem_unit;

  localparam int DATA_W = 35;
  localparam int DEPTH  = 4;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              arst_n;
  logic              write_en;
  logic [DATA_W-1:0] configin;
  logic              clear;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [2:0]        count;
  logic              full;
  logic              overflow;
  logic [1:0]        syskey;

  always #5 clk = ~clk;

  config_mem_unit #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .KEY_INIT (2'b10)
  ) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .write_en (write_en),
    .configin (configin),
    .clear    (clear),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .syskey   (syskey)
  );

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [1:0]        exp_key;
  int                n_checks = 0;
  int                n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key_step();
`ifdef CONFIG_MEM_KEY_ROTATE_EN
    exp_key = exp_key + 2'd1;
`endif
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d, input bit accepted);
    write_en = 1'b1;
    configin = d;
    tick();
    write_en = 1'b0;
    if (accepted) begin
      exp_q.push_back(d);
      key_step();
    end
  endtask

  task automatic pop_check(input string tag);
    logic [DATA_W-1:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, 64'(rd_valid), 64'd1);
    check(tag, 64'(rd_data), 64'(e));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    arst_n   = 1'b0;
    write_en = 1'b1;
    configin = 35'h7ABC;
    clear    = 1'b0;
    rd_ready = 1'b0;
    exp_key  = 2'b10;

    // 1 Reset held two cycles with write_en high.
    tick();
    tick();
    check("rst_count",    64'(count),    64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_full",     64'(full),     64'd0);
    check("rst_syskey",   64'(syskey),   64'd2);
    arst_n   = 1'b1;
    write_en = 1'b0;
    tick();
    check("idle_count", 64'(count), 64'd0);

    // 2 Order, first-word fall-through; key rotation from reset.
    push_word(35'h1, 1'b1);
    check("lat_rd_valid", 64'(rd_valid), 64'd1);
    check("lat_rd_data",  64'(rd_data),  64'h1);
    check("key_1",        64'(syskey),   64'(exp_key));
    push_word(35'h2, 1'b1);
    check("key_2",        64'(syskey),   64'(exp_key));
    push_word(35'h3, 1'b1);
    check("ord_count",    64'(count),    64'd3);
    check("ord_head",     64'(rd_data),  64'h1);
    check("key_3",        64'(syskey),   64'(exp_key));
    tick();
    check("ord_hold",     64'(rd_data),  64'h1);
    for (int i = 0; i < 3; i++) pop_check("ord_rd");
    check("ord_empty_valid", 64'(rd_valid), 64'd0);
    check("ord_empty_count", 64'(count),    64'd0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("rd_on_empty_count", 64'(count), 64'd0);

    // 3 Overflow: fifth push dropped, key unchanged by it.
    for (int i = 0; i < 4; i++) push_word(35'h4_0000_00A0 + 35'(i), 1'b1);
    check("fill_full",     64'(full),     64'd1);
    check("fill_count",    64'(count),    64'd4);
    check("fill_overflow", 64'(overflow), 64'd0);
    push_word(35'h4_0000_00A4, 1'b0);
    check("ovf_flag",   64'(overflow), 64'd1);
    check("ovf_count",  64'(count),    64'd4);
    check("ovf_syskey", 64'(syskey),   64'(exp_key));
    for (int i = 0; i < 4; i++) pop_check("ovf_rd");
    check("ovf_sticky", 64'(overflow), 64'd1);
    push_word(35'h0_0000_00B0, 1'b1);
    push_word(35'h0_0000_00B1, 1'b1);
    check("pre_clr_count", 64'(count), 64'd2);
    // Clear with push and pop requested: both ignored, key untouched.
    clear    = 1'b1;
    write_en = 1'b1;
    rd_ready = 1'b1;
    configin = 35'h0_0000_0BAD;
    tick();
    clear    = 1'b0;
    write_en = 1'b0;
    rd_ready = 1'b0;
    exp_q.delete();
    check("clr_count",    64'(count),    64'd0);
    check("clr_overflow", 64'(overflow), 64'd0);
    check("clr_rd_valid", 64'(rd_valid), 64'd0);
    check("clr_syskey",   64'(syskey),   64'(exp_key));

    // 4 Full with simultaneous push and pop, pointers wrap 3->0.
    for (int i = 0; i < 4; i++) push_word(35'h2_0000_0C00 + 35'(i), 1'b1);
    check("sim_pre_full", 64'(full), 64'd1);
    for (int i = 0; i < 4; i++) begin
      logic [DATA_W-1:0] e;
      logic [DATA_W-1:0] d;
      d = 35'h2_0000_0C04 + 35'(i);
      e = exp_q.pop_front();
      check("sim_head", 64'(rd_data), 64'(e));
      write_en = 1'b1;
      rd_ready = 1'b1;
      configin = d;
      tick();
      write_en = 1'b0;
      rd_ready = 1'b0;
      exp_q.push_back(d);
      key_step();
      check("sim_count",    64'(count),    64'd4);
      check("sim_overflow", 64'(overflow), 64'd0);
    end
    check("sim_syskey", 64'(syskey), 64'(exp_key));
    for (int i = 0; i < 4; i++) pop_check("sim_rd");

    // 5 Reset mid-operation discards contents.
    push_word(35'h3_0000_00D0, 1'b1);
    push_word(35'h3_0000_00D1, 1'b1);
    check("mid_pre_count", 64'(count), 64'd2);
    arst_n   = 1'b0;
    write_en = 1'b1;
    configin = 35'h3_0000_0DDD;
    tick();
    arst_n   = 1'b1;
    write_en = 1'b0;
    exp_q.delete();
    exp_key = 2'b10;
    check("mid_count",    64'(count),    64'd0);
    check("mid_rd_valid", 64'(rd_valid), 64'd0);
    check("mid_syskey",   64'(syskey),   64'(exp_key));
    push_word(35'h5_0000_00E0, 1'b1);
    check("post_rst_count",  64'(count),  64'd1);
    check("post_rst_syskey", 64'(syskey), 64'(exp_key));
    pop_check("post_rst_rd");
    check("final_empty", 64'(rd_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
